uart_dsp_regif: RTL

UART_DSP_REGIF -- requirements
Module: uart_dsp_regif

---
 rtl/uart_dsp_regif_if.sv | 19 +
 rtl/uart_dsp_regif.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_dsp_regif_if.sv
// Host-side register bus of the UART DSP register interface: one access per
// cycle while DSP_CEn is low, read data registered by the slave.
interface uart_dsp_regif_if;
    logic        DSP_CEn;
    logic [3:0]  DSP_ADDR;
    logic        DSP_WEn;
    logic [15:0] DSP_WDATA;
    logic [15:0] DSP_RDATA;

    modport master (
        output DSP_CEn, DSP_ADDR, DSP_WEn, DSP_WDATA,
        input  DSP_RDATA
    );

    modport slave (
        input  DSP_CEn, DSP_ADDR, DSP_WEn, DSP_WDATA,
        output DSP_RDATA
    );
endinterface

// File: rtl/uart_dsp_regif.sv
// UART register interface for the DSP host bus: register file, TX/RX byte
// FIFOs toward the UART core, sticky interrupt status and a registered IRQn.
module uart_dsp_regif #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic              DSP0_CLK,
    input  logic              RESETn,
    uart_dsp_regif_if.slave   bus,
    output logic [7:0]        TX_DATA,
    output logic              TX_VALID,
    input  logic              TX_READY,
    input  logic [7:0]        RX_DATA,
    input  logic              RX_VALID,
    input  logic              RX_ERR,
    input  logic              RX_TOUT,
    input  logic              CORE_BUSY,
    output logic [7:0]        LCR_O,
    output logic [7:0]        CR_O,
    output logic [15:0]       IBRD_O,
    output logic              IRQn
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [3:0] {
        A_DR   = 4'd0,
        A_LCR  = 4'd1,
        A_FCR  = 4'd2,
        A_CR   = 4'd3,
        A_FR   = 4'd4,
        A_IER  = 4'd5,
        A_ISR  = 4'd6,
        A_IBRD = 4'd7
    } reg_addr_e;

    // Threshold codes 00/01/10/11 map to 1/8, 1/4, 1/2 and 3/4 of the depth.
    function automatic logic [AW:0] thr_level(input logic [1:0] code);
        case (code)
            2'b00:   return DEPTH_C >> 3;
            2'b01:   return DEPTH_C >> 2;
            2'b10:   return DEPTH_C >> 1;
            default: return (DEPTH_C >> 1) + (DEPTH_C >> 2);
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    logic acc_wr, acc_rd;
    logic wr_dr, wr_lcr, wr_fcr, wr_cr, wr_ier, wr_isr, wr_ibrd;
    logic rd_dr;

    assign acc_wr  = !bus.DSP_CEn && !bus.DSP_WEn;
    assign acc_rd  = !bus.DSP_CEn &&  bus.DSP_WEn;
    assign wr_dr   = acc_wr && (bus.DSP_ADDR == A_DR);
    assign wr_lcr  = acc_wr && (bus.DSP_ADDR == A_LCR);
    assign wr_fcr  = acc_wr && (bus.DSP_ADDR == A_FCR);
    assign wr_cr   = acc_wr && (bus.DSP_ADDR == A_CR);
    assign wr_ier  = acc_wr && (bus.DSP_ADDR == A_IER);
    assign wr_isr  = acc_wr && (bus.DSP_ADDR == A_ISR);
    assign wr_ibrd = acc_wr && (bus.DSP_ADDR == A_IBRD);
    assign rd_dr   = acc_rd && (bus.DSP_ADDR == A_DR);

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    logic [7:0]  lcr_q, cr_q, ier_q;
    logic [15:0] ibrd_q;
    logic [5:0]  fcr_cfg_q;     // FCR[7:2]; flush bits are never stored

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge DSP0_CLK or negedge RESETn) begin
        if (!RESETn) begin
            lcr_q     <= '0;
            cr_q      <= '0;
            ier_q     <= '0;
            ibrd_q    <= '0;
            fcr_cfg_q <= '0;
        end else begin
            if (wr_lcr)  lcr_q     <= bus.DSP_WDATA[7:0];
            if (wr_cr)   cr_q      <= bus.DSP_WDATA[7:0];
            if (wr_ier)  ier_q     <= bus.DSP_WDATA[7:0];
            if (wr_ibrd) ibrd_q    <= bus.DSP_WDATA;
            if (wr_fcr)  fcr_cfg_q <= bus.DSP_WDATA[7:2];
        end
    end

    assign LCR_O  = lcr_q;
    assign CR_O   = cr_q;
    assign IBRD_O = ibrd_q;

    logic [AW:0] tx_thr, rx_thr;
    assign tx_thr = thr_level(fcr_cfg_q[1:0]);
    assign rx_thr = thr_level(fcr_cfg_q[5:4]);

    // ------------------------------------------------------------------
    // TX FIFO: host pushes through DR, core pops on TX_VALID & TX_READY
    // ------------------------------------------------------------------
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wp_q, tx_rp_q;
    logic [AW:0]   tx_cnt_q, tx_cnt_d;
    logic          tx_full, tx_empty, tx_pop, tx_push, tx_flush;

    assign tx_full  = (tx_cnt_q == DEPTH_C);
    assign tx_empty = (tx_cnt_q == '0);
    assign tx_pop   = !tx_empty && TX_READY;
    assign tx_push  = wr_dr && (!tx_full || tx_pop);
    assign tx_flush = wr_fcr && bus.DSP_WDATA[0];

    // NOTE: always_comb assigns a default first so no path can infer a latch.
    always_comb begin
        tx_cnt_d = tx_cnt_q;
        if (tx_flush)
            tx_cnt_d = '0;
        else if (tx_push && !tx_pop)
            tx_cnt_d = tx_cnt_q + (AW+1)'(1);
        else if (!tx_push && tx_pop)
            tx_cnt_d = tx_cnt_q - (AW+1)'(1);
    end

    always_ff @(posedge DSP0_CLK or negedge RESETn) begin
        if (!RESETn) begin
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            tx_cnt_q <= tx_cnt_d;
            if (tx_flush) begin
                tx_wp_q <= '0;
                tx_rp_q <= '0;
            end else begin
                if (tx_push) tx_wp_q <= tx_wp_q + AW'(1);
                if (tx_pop)  tx_rp_q <= tx_rp_q + AW'(1);
            end
        end
    end

    // NOTE: FIFO storage has no reset; the counts gate every observable read,
    // so stale contents are never seen.
    always_ff @(posedge DSP0_CLK) begin
        if (tx_push) tx_mem[tx_wp_q] <= bus.DSP_WDATA[7:0];
    end

    assign TX_VALID = !tx_empty;
    assign TX_DATA  = tx_empty ? 8'h00 : tx_mem[tx_rp_q];

    // ------------------------------------------------------------------
    // RX FIFO: core pushes on RX_VALID, host pops through DR reads
    // ------------------------------------------------------------------
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wp_q, rx_rp_q;
    logic [AW:0]   rx_cnt_q, rx_cnt_d;
    logic          rx_full, rx_empty, rx_pop, rx_push, rx_flush, rx_ovr;

    assign rx_full  = (rx_cnt_q == DEPTH_C);
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_pop   = rd_dr && !rx_empty;
    assign rx_push  = RX_VALID && (!rx_full || rx_pop);
    assign rx_ovr   = RX_VALID && rx_full && !rx_pop;
    assign rx_flush = wr_fcr && bus.DSP_WDATA[1];

    always_comb begin
        rx_cnt_d = rx_cnt_q;
        if (rx_flush)
            rx_cnt_d = '0;
        else if (rx_push && !rx_pop)
            rx_cnt_d = rx_cnt_q + (AW+1)'(1);
        else if (!rx_push && rx_pop)
            rx_cnt_d = rx_cnt_q - (AW+1)'(1);
    end

    always_ff @(posedge DSP0_CLK or negedge RESETn) begin
        if (!RESETn) begin
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            rx_cnt_q <= rx_cnt_d;
            if (rx_flush) begin
                rx_wp_q <= '0;
                rx_rp_q <= '0;
            end else begin
                if (rx_push) rx_wp_q <= rx_wp_q + AW'(1);
                if (rx_pop)  rx_rp_q <= rx_rp_q + AW'(1);
            end
        end
    end

    always_ff @(posedge DSP0_CLK) begin
        if (rx_push) rx_mem[rx_wp_q] <= RX_DATA;
    end

    // ------------------------------------------------------------------
    // Interrupt status: sticky, write-1-to-clear, set beats clear
    // ------------------------------------------------------------------
    logic [3:0] isr_q, isr_set, isr_clr;
    logic       irq_n_q;

    always_comb begin
        isr_set    = '0;
        isr_set[3] = (tx_cnt_q > tx_thr) && (tx_cnt_d <= tx_thr);
        isr_set[2] = (rx_cnt_q < rx_thr) && (rx_cnt_d >= rx_thr);
        isr_set[1] = RX_TOUT && !rx_empty;
        isr_set[0] = RX_ERR || rx_ovr;
        isr_clr    = wr_isr ? bus.DSP_WDATA[3:0] : 4'h0;
    end

    always_ff @(posedge DSP0_CLK or negedge RESETn) begin
        if (!RESETn) begin
            isr_q   <= '0;
            irq_n_q <= 1'b1;
        end else begin
            isr_q   <= (isr_q & ~isr_clr) | isr_set;
            irq_n_q <= ~|(isr_q & ier_q[3:0]);
        end
    end

    assign IRQn = irq_n_q;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [15:0] rd_val, rdata_q;

    always_comb begin
        rd_val = '0;
        case (bus.DSP_ADDR)
            A_DR:    rd_val = rx_empty ? 16'h0000 : {8'h00, rx_mem[rx_rp_q]};
            A_LCR:   rd_val = {8'h00, lcr_q};
            A_FCR:   rd_val = {8'h00, fcr_cfg_q, 2'b00};
            A_CR:    rd_val = {8'h00, cr_q};
            A_FR:    rd_val = {8'h00, tx_full, tx_empty, 1'b0, rx_empty,
                               rx_full, 2'b00, CORE_BUSY};
            A_IER:   rd_val = {8'h00, ier_q};
            A_ISR:   rd_val = {12'h000, isr_q};
            A_IBRD:  rd_val = ibrd_q;
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge DSP0_CLK or negedge RESETn) begin
        if (!RESETn)
            rdata_q <= '0;
        else if (acc_rd)
            rdata_q <= rd_val;
    end

    assign bus.DSP_RDATA = rdata_q;

endmodule
